// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer: buffers 24-bit stereo pairs in a small FIFO and shifts them
// MSB-first on DACDAT, timed by the codec's BCLK/DACLRCK resynchronised into clk.
module audio_dac_serializer #(
  parameter int DATA_W    = 24,
  parameter int LOG_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] writedata_left_i,
  input  logic [DATA_W-1:0] writedata_right_i,
  output logic              write_ready_o,
  input  logic              bclk_i,
  input  logic              daclrck_i,
  output logic              dacdat_o,
  output logic              underflow_o
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [LOG_DEPTH:0] FULL_C = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   BITS_C = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]   LAST_C = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {WAIT_SYNC, DELAY, SHIFT, PAD} state_t;

  // [0],[1] are the synchronizer; [2] is the delay stage used for edge decode
  logic [2:0] bclk_sync_q, lr_sync_q;
  logic       bclk_fall, lr_fall, lr_rise;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], bclk_i};
      lr_sync_q   <= {lr_sync_q[1:0], daclrck_i};
    end
  end

  assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lr_fall   = lr_sync_q[2]   & ~lr_sync_q[1];
  assign lr_rise   = ~lr_sync_q[2]  & lr_sync_q[1];

  logic [2*DATA_W-1:0]  mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]   count_q;
  logic                 full, empty, push, pop;
  logic [2*DATA_W-1:0]  rd_data;

  assign full          = (count_q == FULL_C);
  assign empty         = (count_q == '0);
  assign write_ready_o = ~full;
  assign push          = write_i & ~full;
  // A push landing on an empty FIFO in the pop cycle is not visible to that pop
  assign pop           = lr_fall & ~empty;
  assign rd_data       = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {writedata_left_i, writedata_right_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, hold_q, hold_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              dacdat_q, dacdat_d, underflow_q, underflow_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= WAIT_SYNC;
      shreg_q     <= '0;
      hold_q      <= '0;
      bitcnt_q    <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      bitcnt_q    <= bitcnt_d;
      dacdat_q    <= dacdat_d;
      underflow_q <= underflow_d;
    end
  end

  // LR edges take priority and swallow a coincident bclk_fall
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    bitcnt_d    = bitcnt_q;
    dacdat_d    = dacdat_q;
    underflow_d = 1'b0;
    if (lr_fall) begin
      state_d     = DELAY;
      bitcnt_d    = '0;
      underflow_d = empty;
      shreg_d     = empty ? '0 : rd_data[2*DATA_W-1:DATA_W];
      hold_d      = empty ? '0 : rd_data[DATA_W-1:0];
    end else if (lr_rise && state_q != WAIT_SYNC) begin
      state_d  = DELAY;
      bitcnt_d = '0;
      shreg_d  = hold_q;
    end else if (bclk_fall) begin
      case (state_q)
        DELAY: state_d = SHIFT;
        SHIFT: begin
          dacdat_d = shreg_q[DATA_W-1];
          shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
          if (bitcnt_q < BITS_C) bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_C) state_d = PAD;
        end
        PAD:     dacdat_d = 1'b0;
        default: dacdat_d = 1'b0;
      endcase
    end
  end

  assign dacdat_o    = dacdat_q;
  assign underflow_o = underflow_q;

endmodule
